rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port (we/wa/wd) between two writeback sources: ALU results (source A) and memory-load results (source M).
- M always wins; A writes that lose arbitration are held in a small in-order FIFO and drained on idle cycles.
- Squashes stale buffered writes (WAW) and reports pending-write hazards so decode can stall reads of in-flight registers.
- Sits between the execute/memory stages and the register file; its outputs drive the register file's we/wa/wd inputs directly.

---
 rtl/rf_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Arbitrates the single register-file write port between ALU
//                writebacks (source A) and load writebacks (source M).  M
//                always wins.  A writes that lose arbitration wait in a small
//                in-order FIFO and drain on idle cycles.  Buffered writes
//                overwritten by a younger load are squashed (WAW), and decode
//                read addresses are checked against every pending write.
//                Optional build macro WB_ARB_STATS_EN enables the A-side
//                backpressure cycle counter on stall_cnt; otherwise stall_cnt
//                is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DATAW = 32,
    parameter int ADDRW = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    // ALU writeback source
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [ADDRW-1:0] a_addr,
    input  logic [DATAW-1:0] a_data,
    // Load writeback source (never back-pressured)
    input  logic             m_valid,
    input  logic [ADDRW-1:0] m_addr,
    input  logic [DATAW-1:0] m_data,
    // Register-file write port
    output logic             we,
    output logic [ADDRW-1:0] wa,
    output logic [DATAW-1:0] wd,
    // Decode hazard query
    input  logic [ADDRW-1:0] q_addr1,
    input  logic [ADDRW-1:0] q_addr2,
    output logic             hz1,
    output logic             hz2,
    // Backpressure statistics
    output logic [15:0]      stall_cnt
);

    // Pointer and occupancy widths; DEPTH is a power of two >= 2, so the
    // pointers wrap naturally and the count needs one extra bit for "full".
    localparam int              c_PW        = $clog2(DEPTH);
    localparam int              c_CW        = c_PW + 1;
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_ZERO_CNT  = '0;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_CW-1:0]  r_count;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [ADDRW-1:0] r_fifo_addr [DEPTH];
    logic [DATAW-1:0] r_fifo_data [DEPTH];
    logic [DEPTH-1:0] r_fifo_vld;

    logic             r_we;
    logic [ADDRW-1:0] r_wa;
    logic [DATAW-1:0] r_wd;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic             w_fifo_nonempty;
    logic             w_a_xfer;
    logic             w_issue_m;
    logic             w_issue_pop;
    logic             w_issue_a;
    logic             w_push;
    logic [DEPTH-1:0] w_squash;
    logic [ADDRW-1:0] w_head_addr;
    logic [DATAW-1:0] w_head_data;
    logic             w_head_vld;
    logic             w_hz1;
    logic             w_hz2;

    // Ready depends only on registered occupancy, so a full FIFO that pops
    // this cycle still refuses A until the next cycle.
    assign a_ready         = (r_count < c_DEPTH_CNT);
    assign w_fifo_nonempty = (r_count != c_ZERO_CNT);
    assign w_a_xfer        = a_valid & a_ready;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_head_vld  = r_fifo_vld[r_rd_ptr];

    // Issue priority: load, then FIFO head, then a direct ALU bypass.  An A
    // transfer that is not issued directly is always buffered behind older
    // work, which keeps A strictly after a same-cycle (older) load.
    always_comb begin
        w_issue_m   = 1'b0;
        w_issue_pop = 1'b0;
        w_issue_a   = 1'b0;
        w_push      = 1'b0;
        if (m_valid) begin
            w_issue_m = 1'b1;
            w_push    = w_a_xfer;
        end else if (w_fifo_nonempty) begin
            w_issue_pop = 1'b1;
            w_push      = w_a_xfer;
        end else begin
            w_issue_a = w_a_xfer;
        end
    end

    // WAW squash mask: only entries already valid before this edge are
    // candidates, so a same-cycle A push to the same register survives.
    always_comb begin
        w_squash = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_squash[i] = m_valid && r_fifo_vld[i] && (r_fifo_addr[i] == m_addr);
        end
    end

    // Pending-write hazard check: any live FIFO entry or the output stage,
    // because the register file cannot yet see the write being issued now.
    always_comb begin
        w_hz1 = r_we && (r_wa == q_addr1);
        w_hz2 = r_we && (r_wa == q_addr2);
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fifo_vld[i] && (r_fifo_addr[i] == q_addr1)) begin
                w_hz1 = 1'b1;
            end
            if (r_fifo_vld[i] && (r_fifo_addr[i] == q_addr2)) begin
                w_hz2 = 1'b1;
            end
        end
    end

    assign hz1 = w_hz1;
    assign hz2 = w_hz2;

    // ------------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------------

    // Entry payload and valid bits; a squash clears the valid bit but keeps
    // the slot occupied so pop order and occupancy stay untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fifo_vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_addr[i] <= '0;
                r_fifo_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_squash[i]) begin
                    r_fifo_vld[i] <= 1'b0;
                end
            end
            if (w_issue_pop) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
            end
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= a_addr;
                r_fifo_data[r_wr_ptr] <= a_data;
                r_fifo_vld[r_wr_ptr]  <= 1'b1;
            end
        end
    end

    // Read/write pointers and occupancy; pop and push together leave the
    // count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_issue_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_issue_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Register-file write stage
    // ------------------------------------------------------------------------

    // One write per cycle; address/data hold when nothing (or a squashed
    // entry) is issued so the register file sees a stable bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we <= 1'b0;
            r_wa <= '0;
            r_wd <= '0;
        end else if (w_issue_m) begin
            r_we <= 1'b1;
            r_wa <= m_addr;
            r_wd <= m_data;
        end else if (w_issue_pop) begin
            r_we <= w_head_vld;
            if (w_head_vld) begin
                r_wa <= w_head_addr;
                r_wd <= w_head_data;
            end
        end else if (w_issue_a) begin
            r_we <= 1'b1;
            r_wa <= a_addr;
            r_wd <= a_data;
        end else begin
            r_we <= 1'b0;
        end
    end

    assign we = r_we;
    assign wa = r_wa;
    assign wd = r_wd;

    // ------------------------------------------------------------------------
    // Optional backpressure statistics
    // ------------------------------------------------------------------------
`ifdef WB_ARB_STATS_EN
    logic [15:0] r_stall_cnt;

    // Count cycles where A is presented but refused, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= 16'h0000;
        end else if (a_valid && !a_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter.  Directed scenarios
//                followed by randomized traffic, compared against a
//                queue-based reference model of the writeback rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int DATAW = 32;
    localparam int ADDRW = 4;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset;
    logic             a_valid;
    logic             a_ready;
    logic [ADDRW-1:0] a_addr;
    logic [DATAW-1:0] a_data;
    logic             m_valid;
    logic [ADDRW-1:0] m_addr;
    logic [DATAW-1:0] m_data;
    logic             we;
    logic [ADDRW-1:0] wa;
    logic [DATAW-1:0] wd;
    logic [ADDRW-1:0] q_addr1;
    logic [ADDRW-1:0] q_addr2;
    logic             hz1;
    logic             hz2;
    logic [15:0]      stall_cnt;

    rf_wb_arbiter #(
        .DATAW (DATAW),
        .ADDRW (ADDRW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .q_addr1   (q_addr1),
        .q_addr2   (q_addr2),
        .hz1       (hz1),
        .hz2       (hz2),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pending A writes in program order, plus output stage
    typedef struct {
        logic [ADDRW-1:0] addr;
        logic [DATAW-1:0] data;
        logic             vld;
    } ent_t;

    ent_t             mq[$];
    logic             m_we;
    logic [ADDRW-1:0] m_wa;
    logic [DATAW-1:0] m_wd;
    logic [15:0]      m_stall;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hz(input logic [ADDRW-1:0] q);
        logic h;
        h = m_we && (m_wa == q);
        foreach (mq[i]) begin
            if (mq[i].vld && mq[i].addr == q) h = 1'b1;
        end
        return h;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_we    = 1'b0;
        m_wa    = '0;
        m_wd    = '0;
        m_stall = 16'h0000;
    endtask

    // One clock cycle: apply inputs, check combinational outputs, advance
    // the model, then check the registered outputs after the edge.
    task automatic cyc(input logic av, input logic [ADDRW-1:0] aa, input logic [DATAW-1:0] ad,
                       input logic mv, input logic [ADDRW-1:0] ma, input logic [DATAW-1:0] md,
                       input logic [ADDRW-1:0] q1, input logic [ADDRW-1:0] q2);
        logic rdy;
        logic x;
        ent_t h;
        ent_t n;
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        m_valid = mv; m_addr = ma; m_data = md;
        q_addr1 = q1; q_addr2 = q2;
        #1;
        rdy = (mq.size() < DEPTH);
        chk("a_ready", 32'(a_ready), 32'(rdy));
        chk("hz1", 32'(hz1), 32'(model_hz(q1)));
        chk("hz2", 32'(hz2), 32'(model_hz(q2)));
        x = av && rdy;
        n.addr = aa; n.data = ad; n.vld = 1'b1;
`ifdef WB_ARB_STATS_EN
        if (av && !rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'h0001;
`endif
        if (mv) begin
            foreach (mq[i]) if (mq[i].addr == ma) mq[i].vld = 1'b0;
            m_we = 1'b1; m_wa = ma; m_wd = md;
            if (x) mq.push_back(n);
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = h.vld;
            if (h.vld) begin
                m_wa = h.addr; m_wd = h.data;
            end
            if (x) mq.push_back(n);
        end else if (x) begin
            m_we = 1'b1; m_wa = aa; m_wd = ad;
        end else begin
            m_we = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("we", 32'(we), 32'(m_we));
        chk("wa", 32'(wa), 32'(m_wa));
        chk("wd", wd, m_wd);
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    endtask

    task automatic idle();
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd14, 4'd13);
    endtask

    // Asynchronous reset pulse asserted mid-cycle with current inputs held
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0; a_valid = 1'b0; m_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        q_addr1 = '0; q_addr2 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_we", 32'(we), 32'd0);
        chk("init_wa", 32'(wa), 32'd0);
        chk("init_wd", wd, 32'd0);
        chk("init_ready", 32'(a_ready), 32'd1);
        chk("init_hz1", 32'(hz1), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Solo A bypass, hazard visible while the write sits in the output stage
        cyc(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0, 4'd3, 4'd4);
        chk("soloA_we", 32'(we), 32'd1);
        chk("soloA_wa", 32'(wa), 32'd3);
        chk("soloA_wd", wd, 32'hDEADBEEF);
        q_addr1 = 4'd3; q_addr2 = 4'd4;
        #1;
        chk("soloA_hz1", 32'(hz1), 32'd1);
        chk("soloA_hz2", 32'(hz2), 32'd0);
        idle();

        // Same-cycle collision: M (older) lands first, then A
        cyc(1'b1, 4'd5, 32'h22, 1'b1, 4'd5, 32'h11, 4'd5, 4'd0);
        chk("coll_wd1", wd, 32'h11);
        cyc(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 4'd5, 4'd0);
        chk("coll_wa2", 32'(wa), 32'd5);
        chk("coll_wd2", wd, 32'h22);
        idle();
        chk("coll_done", 32'(we), 32'd0);

        // WAW squash: buffered r7=AA killed by younger M r7=BB
        cyc(1'b1, 4'd7, 32'hAA, 1'b1, 4'd9, 32'h01, 4'd7, 4'd9);
        cyc(1'b0, 4'd0, 32'h0, 1'b1, 4'd7, 32'hBB, 4'd7, 4'd9);
        chk("waw_wd", wd, 32'hBB);
        idle();
        chk("waw_squash_we", 32'(we), 32'd0);
        idle();
        chk("waw_empty_ready", 32'(a_ready), 32'd1);

        // Backpressure: 4 cycles of M with A every cycle
        do_reset();
        cyc(1'b1, 4'd1, 32'hA1, 1'b1, 4'd10, 32'hB0, 4'd1, 4'd2);
        cyc(1'b1, 4'd2, 32'hA2, 1'b1, 4'd11, 32'hB1, 4'd1, 4'd2);
        chk("bp_full", 32'(a_ready), 32'd0);
        cyc(1'b1, 4'd3, 32'hA3, 1'b1, 4'd12, 32'hB2, 4'd1, 4'd3);
        cyc(1'b1, 4'd3, 32'hA3, 1'b1, 4'd13, 32'hB3, 4'd1, 4'd3);
`ifdef WB_ARB_STATS_EN
        chk("bp_stall", 32'(stall_cnt), 32'd2);
`else
        chk("bp_stall", 32'(stall_cnt), 32'd0);
`endif
        idle();
        chk("bp_drain1", wd, 32'hA1);
        idle();
        chk("bp_drain2", wd, 32'hA2);
        idle();

        // Pop+push with count=1
        cyc(1'b1, 4'd1, 32'hC1, 1'b1, 4'd8, 32'hC0, 4'd1, 4'd2);
        cyc(1'b1, 4'd2, 32'hC2, 1'b0, 4'd0, 32'h0, 4'd1, 4'd2);
        chk("pp_head", wd, 32'hC1);
        chk("pp_ready", 32'(a_ready), 32'd1);
        idle();
        chk("pp_next", wd, 32'hC2);

        // Reset mid-drain: r1, r2 buffered, then reset; they never appear
        cyc(1'b1, 4'd1, 32'hE1, 1'b1, 4'd8, 32'hF0, 4'd1, 4'd2);
        cyc(1'b1, 4'd2, 32'hE2, 1'b1, 4'd9, 32'hF1, 4'd1, 4'd2);
        do_reset();
        for (int k = 0; k < 4; k++) begin
            idle();
            chk("rst_nowrite", 32'(we), 32'd0);
        end

        // Randomized traffic with a small address range to provoke conflicts
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            cyc(1'($urandom_range(0, 9) < 6), 4'($urandom_range(0, 3)), $urandom,
                1'($urandom_range(0, 9) < 4), 4'($urandom_range(0, 3)), $urandom,
                4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
